riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32 core. It sequences a shared datapath with one unified byte-addressed memory, one ALU, and IR/OldPC/ALUOut/Data holding registers, driving every mux select and write enable cycle by cycle. It supports lw, sw, R-type and I-type add/sub/slt/or/and, beq, bne and jal. ALU decode encodings match the single-cycle core: add=000, sub=001, and=010, or=011, slt=101.

Parameters:
STATE_W, 4, width of the state encoding on the debug port

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0], stable from the cycle after FETCH
funct3  in  3  IR[14:12]
funct7_5  in  1  IR[30]
zero  in  1  ALU result == 0
PCWrite  out  1  PC register load enable
AdrSrc  out  1  memory address select: 0=PC, 1=Result
MemWrite  out  1  memory write enable
IRWrite  out  1  loads IR and OldPC
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1 register
ALUSrcB  out  2  00=RD2 register, 01=ImmExt, 10=constant 4
ALUControl  out  3  ALU operation
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
instr_done  out  1  one-cycle pulse in the last state of each instruction
illegal  out  1  high while in TRAP
state  out  STATE_W  current state, for debug

Behaviour:
- Reset: while reset=1 every output is 0 except state. On each clk edge with reset=1, state is loaded with FETCH. The first cycle after release is FETCH. Reset asserted mid-instruction aborts it at the next edge with no further writes.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=11.
- All outputs except PCWrite and ImmSrc are Moore, decoded from state. ImmSrc is decoded from opcode only: lw/I-type=00, sw=01, branch=10, jal=11, others=00.
- Any signal not listed for a state is 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALU=add, ResultSrc=10, PC update. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALU=add (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - otherwise -> TRAP
- DECODE also traps for: R/I-type funct3 not in {000,010,110,111}; branch funct3 not in {000,001}; lw/sw funct3 != 010.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU=add. Next: MEMREAD if opcode[5]=0, MEMWRITE if opcode[5]=1.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, instr_done=1. Next: FETCH.
- EXECR / EXECI: ALUSrcA=10, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl from funct3: 000=add, or sub when EXECR and funct7_5=1; 010=slt; 110=or; 111=and. funct7_5 is ignored in EXECI. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALU=add, ResultSrc=00, PC update. Next: ALUWB (rd <= OldPC+4).
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALU=sub, ResultSrc=00, branch=1, instr_done=1. Next: FETCH.
- TRAP: illegal=1, no enables asserted. Stays in TRAP until reset.
- PCWrite = PCupdate | (branch & (funct3[0] ? ~zero : zero)).
- In every state other than EXECR/EXECI/BRANCH, ALUControl=000.
- Latency in cycles, FETCH to the next FETCH: lw 5, sw 4, R/I 4, jal 4, beq/bne 3.

Test Plan:
- Release reset with IR=lw x5,8(x0) (opcode 0000011, funct3 010) -> state sequence 0,1,2,3,4,0. MemWrite never set; RegWrite=1 only in state 4; instr_done pulses once.
- sw (0100011, funct3 010) -> states 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in state 5; RegWrite stays 0.
- R-type: funct3=000 with funct7_5=1 -> ALUControl=001 in EXECR. I-type: funct3=000 with funct7_5=1 -> ALUControl=000. funct3=111 -> 010, funct3=110 -> 011, funct3=010 -> 101.
- beq with zero=1 -> PCWrite=1 in BRANCH. beq with zero=0 -> PCWrite=0. bne (funct3=001) with zero=0 -> PCWrite=1. Each takes 3 cycles.
- jal (1101111) -> states 0,1,9,7,0. PCWrite=1 in state 9; ImmSrc=11 throughout.
- opcode=0000000 -> TRAP with illegal=1 held for 10+ cycles and all enables 0. Assert reset, also once during MEMREAD -> state=0 on the next edge, with no MemWrite or RegWrite pulse.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32 core: sequences the shared memory/ALU datapath
// one state per cycle, with Moore outputs plus branch-resolved PCWrite and opcode-decoded ImmSrc.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR/OldPC, PC <= PC+4
// DECODE   | read registers, ALUOut <= OldPC+imm (branch target)
// MEMADR   | ALUOut <= rs1+imm
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= OldPC+imm, ALUOut <= OldPC+4
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// TRAP     | unsupported instruction, parked until reset
module riscv_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [STATE_W-1:0] state_q, state_d;
  logic               alu_f3_ok, br_f3_ok, mem_f3_ok;
  logic               pc_update, branch;
  logic [2:0]         alu_op;

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign mem_f3_ok = (funct3 == 3'b010);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: state_d = mem_f3_ok ? S_MEMADR : S_TRAP;
          7'b0110011:             state_d = alu_f3_ok ? S_EXECR  : S_TRAP;
          7'b0010011:             state_d = alu_f3_ok ? S_EXECI  : S_TRAP;
          7'b1100011:             state_d = br_f3_ok  ? S_BRANCH : S_TRAP;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // funct7_5 selects sub only for register-register ops; I-type addi has no subi
  always_comb begin
    case (funct3)
      3'b000:  alu_op = ((state_q == S_EXECR) && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ImmSrc     = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    case (opcode)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
    // funct3[0] distinguishes bne from beq
    PCWrite = pc_update | (branch & (funct3[0] ? ~zero : zero));
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      ImmSrc     = 2'b00;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: per-cycle expected output vectors are queued per
// instruction and compared against the DUT outputs sampled mid-cycle.
module tb_riscv_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, asa, asb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw, done, ill;
  } vec_t;

  vec_t obs, exp_v;
  vec_t sbq[$];

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  assign obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, instr_done, illegal};

  // Expected outputs for one state, straight from the per-state output table
  function automatic vec_t exp_of(input logic [3:0] st, input logic [1:0] imm,
                                  input logic [2:0] alu, input logic pcw);
    vec_t v;
    v = '0;
    v.st = st;
    v.imm = imm;
    case (st)
      4'd0:  begin v.pcw = 1; v.irw = 1; v.rs = 2'b10; v.asb = 2'b10; end
      4'd1:  begin v.asa = 2'b01; v.asb = 2'b01; end
      4'd2:  begin v.asa = 2'b10; v.asb = 2'b01; end
      4'd3:  v.adr = 1;
      4'd4:  begin v.rs = 2'b01; v.rw = 1; v.done = 1; end
      4'd5:  begin v.adr = 1; v.mw = 1; v.done = 1; end
      4'd6:  begin v.asa = 2'b10; v.alu = alu; end
      4'd7:  begin v.rw = 1; v.done = 1; end
      4'd8:  begin v.asa = 2'b10; v.asb = 2'b01; v.alu = alu; end
      4'd9:  begin v.pcw = 1; v.asa = 2'b01; v.asb = 2'b10; end
      4'd10: begin v.pcw = pcw; v.asa = 2'b10; v.alu = 3'b001; v.done = 1; end
      4'd11: v.ill = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic vec_t rst_vec(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      sbq.push_back(rst_vec(4'd0));
      exp_v = sbq.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_load_store();
    int cyc;
    opcode = 7'b0000011; funct3 = 3'b010;
    sbq.push_back(exp_of(4'd0, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd1, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd2, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd3, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd4, 2'b00, 3'b0, 1'b0));
    cyc = 0;
    while (sbq.size() > 0) begin
      #1;
      exp_v = sbq.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h", cyc, obs, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
    opcode = 7'b0100011;
    foreach (sbq[i]) ;
    sbq.push_back(exp_of(4'd0, 2'b01, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd1, 2'b01, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd2, 2'b01, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd5, 2'b01, 3'b0, 1'b0));
    cyc = 0;
    while (sbq.size() > 0) begin
      #1;
      exp_v = sbq.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL sw cyc%0d got=%h want=%h", cyc, obs, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops();
    // {is_r, funct3, funct7_5, expected ALUControl}
    logic [7:0] tbl [9];
    logic [7:0] e;
    tbl = '{ {1'b1, 3'b000, 1'b1, 3'b001}, {1'b1, 3'b000, 1'b0, 3'b000},
             {1'b0, 3'b000, 1'b1, 3'b000}, {1'b1, 3'b111, 1'b0, 3'b010},
             {1'b1, 3'b110, 1'b0, 3'b011}, {1'b1, 3'b010, 1'b0, 3'b101},
             {1'b0, 3'b111, 1'b1, 3'b010}, {1'b0, 3'b110, 1'b0, 3'b011},
             {1'b0, 3'b010, 1'b0, 3'b101} };
    for (int t = 0; t < 9; t++) begin
      e = tbl[t];
      opcode   = e[7] ? 7'b0110011 : 7'b0010011;
      funct3   = e[6:4];
      funct7_5 = e[3];
      sbq.push_back(exp_of(4'd0, 2'b00, 3'b0, 1'b0));
      sbq.push_back(exp_of(4'd1, 2'b00, 3'b0, 1'b0));
      sbq.push_back(exp_of(e[7] ? 4'd6 : 4'd8, 2'b00, e[2:0], 1'b0));
      sbq.push_back(exp_of(4'd7, 2'b00, 3'b0, 1'b0));
      for (int c = 0; sbq.size() > 0; c++) begin
        #1;
        exp_v = sbq.pop_front();
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL alu%0d cyc%0d got=%h want=%h", t, c, obs, exp_v);
        end
        @(negedge clk);
      end
    end
    funct7_5 = 1'b0;
  endtask

  task automatic test_branch();
    // {funct3, zero, expected PCWrite in BRANCH}
    logic [4:0] tbl [4];
    tbl = '{ {3'b000, 1'b1, 1'b1}, {3'b000, 1'b0, 1'b0},
             {3'b001, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b0} };
    opcode = 7'b1100011;
    for (int t = 0; t < 4; t++) begin
      funct3 = tbl[t][4:2];
      zero   = tbl[t][1];
      sbq.push_back(exp_of(4'd0, 2'b10, 3'b0, 1'b0));
      sbq.push_back(exp_of(4'd1, 2'b10, 3'b0, 1'b0));
      sbq.push_back(exp_of(4'd10, 2'b10, 3'b0, tbl[t][0]));
      for (int c = 0; sbq.size() > 0; c++) begin
        #1;
        exp_v = sbq.pop_front();
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL br%0d cyc%0d got=%h want=%h", t, c, obs, exp_v);
        end
        @(negedge clk);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    opcode = 7'b1101111; funct3 = 3'b101;
    sbq.push_back(exp_of(4'd0, 2'b11, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd1, 2'b11, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd9, 2'b11, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd7, 2'b11, 3'b0, 1'b0));
    for (int c = 0; sbq.size() > 0; c++) begin
      #1;
      exp_v = sbq.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL jal cyc%0d got=%h want=%h", c, obs, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    // {opcode, funct3, ImmSrc}
    logic [11:0] tbl [6];
    tbl = '{ {7'b0000000, 3'b000, 2'b00}, {7'b0110011, 3'b001, 2'b00},
             {7'b0010011, 3'b100, 2'b00}, {7'b1100011, 3'b100, 2'b10},
             {7'b0000011, 3'b000, 2'b00}, {7'b0100011, 3'b001, 2'b01} };
    for (int t = 0; t < 6; t++) begin
      opcode = tbl[t][11:5];
      funct3 = tbl[t][4:2];
      sbq.push_back(exp_of(4'd0, tbl[t][1:0], 3'b0, 1'b0));
      sbq.push_back(exp_of(4'd1, tbl[t][1:0], 3'b0, 1'b0));
      for (int k = 0; k < ((t == 0) ? 12 : 2); k++)
        sbq.push_back(exp_of(4'd11, tbl[t][1:0], 3'b0, 1'b0));
      sbq.push_back(rst_vec(4'd11));
      sbq.push_back(rst_vec(4'd0));
      for (int c = 0; sbq.size() > 0; c++) begin
        if (sbq.size() == 2) reset = 1'b1;
        #1;
        exp_v = sbq.pop_front();
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL trap%0d cyc%0d got=%h want=%h", t, c, obs, exp_v);
        end
        if (sbq.size() > 0) @(negedge clk);
      end
      reset = 1'b0;
    end
  endtask

  task automatic test_reset_mid_instr();
    opcode = 7'b0000011; funct3 = 3'b010;
    sbq.push_back(exp_of(4'd0, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd1, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd2, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd3, 2'b00, 3'b0, 1'b0));
    sbq.push_back(rst_vec(4'd3));
    sbq.push_back(rst_vec(4'd0));
    sbq.push_back(exp_of(4'd0, 2'b00, 3'b0, 1'b0));
    sbq.push_back(exp_of(4'd1, 2'b00, 3'b0, 1'b0));
    for (int c = 0; sbq.size() > 0; c++) begin
      #1;
      exp_v = sbq.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL midrst cyc%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 3) reset = 1'b1;
      else if (c == 5) reset = 1'b0;
      else @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_store();
    test_alu_ops();
    test_branch();
    test_jal();
    test_trap();
    test_reset_mid_instr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
